stage_sequencer: RTL

- Parametrised one-hot stage clock generator; successor to the fixed 6-stage stage clock.
- Walks a single active bit through NUM_STAGES outputs and holds each stage for a programmable dwell count.
- Supports one-shot and continuous loop modes, plus graceful stop at the end of a pass.
- Drives per-stage enables for the datapath pipeline; a done pulse and busy flag go to the control FSM.

---
 rtl/stage_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// One-hot stage clock generator: walks a single active bit across NUM_STAGES enables,
// dwelling a programmable count per stage. Optional abort input via `STAGE_SEQ_ABORT_EN.
module stage_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int DWELL_W    = 4,
  parameter int IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  shift,
  input  logic                  mode,
  input  logic                  stop,
  input  logic [DWELL_W-1:0]    dwell,
`ifdef STAGE_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic [NUM_STAGES-1:0] out,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  debug_in
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_r;
  logic               mode_r;
  logic               stop_pending;
  logic               abort_hit;
  logic               tick;
  logic               last_stage;
  logic               accept;
  logic               wrap;

  function automatic logic [DWELL_W-1:0] dwell_floor(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

`ifdef STAGE_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign tick       = (cnt == DWELL_W'(1));
  assign last_stage = (stage_idx == IDX_W'(NUM_STAGES - 1));
  assign accept     = (state == IDLE) && start;
  // A wrap happens only on the final tick of a loop pass with no stop requested.
  assign wrap       = (state == RUN) && !abort_hit && shift && tick && last_stage &&
                      mode_r && !stop_pending;
  assign debug_in   = accept || wrap;

  // Start-time configuration; never consulted outside RUN, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      dwell_r <= dwell_floor(dwell);
      mode_r  <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out          <= '0;
      stage_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= RUN;
            out          <= NUM_STAGES'(1);
            stage_idx    <= '0;
            busy         <= 1'b1;
            cnt          <= dwell_floor(dwell);
            stop_pending <= 1'b0;
          end
        end
        RUN: begin
          if (abort_hit) begin
            state        <= IDLE;
            out          <= '0;
            stage_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            if (stop && mode_r) stop_pending <= 1'b1;
            if (shift) begin
              if (!tick) begin
                cnt <= cnt - DWELL_W'(1);
              end else if (!last_stage) begin
                out       <= out << 1;
                stage_idx <= stage_idx + IDX_W'(1);
                cnt       <= dwell_r;
              end else if (!mode_r || stop_pending) begin
                state <= DONE;
                out   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                out       <= NUM_STAGES'(1);
                stage_idx <= '0;
                cnt       <= dwell_r;
              end
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b0;
          stop_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
